// File: rtl/neighbor_bank_reader_pkg.sv
// Shared types and constants for the neighbor memory path: controller-to-bank requests and
// bank-to-PE return beats.
package neighbor_bank_reader_pkg;

    localparam int unsigned Neighbor_Addr_W    = 8;
    localparam int unsigned Neighbor_Data_W    = 16;
    localparam int unsigned PE_Tag_W           = 4;
    localparam int unsigned Max_Neighbors      = 32;
    localparam int unsigned Num_Banks_Neighbor = 4;

    typedef struct packed {
        logic                       valid;
        logic [PE_Tag_W-1:0]        PE_tag;
        logic [Neighbor_Addr_W-1:0] Bank_addr;
    } Neighbor_MEM_CNTL2Neighbor_Bank_CNTL;

    typedef struct packed {
        logic                       valid;
        logic [PE_Tag_W-1:0]        PE_tag;
        logic [Neighbor_Data_W-1:0] data;
        logic                       last;
        logic                       empty;
    } Neighbor_Bank2PE;

endpackage

// File: rtl/neighbor_bank_reader.sv
// Per-bank read engine: fetches a length-prefixed neighbor list from one SRAM bank and streams
// its entries to the PE return path with valid/ready.
module neighbor_bank_reader
    import neighbor_bank_reader_pkg::*;
#(
    parameter int unsigned ADDR_W  = Neighbor_Addr_W,
    parameter int unsigned DATA_W  = Neighbor_Data_W,
    parameter int unsigned TAG_W   = PE_Tag_W,
    parameter int unsigned MAX_NBR = Max_Neighbors
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [TAG_W-1:0]  req_PE_tag,
    input  logic [ADDR_W-1:0] req_bank_addr,
    output logic              busy,
    output logic              sram_re,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAG_W-1:0]  out_PE_tag,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_empty,
    output logic              err_collision,
    output logic              err_overflow
);

    localparam int unsigned REM_W = $clog2(MAX_NBR + 1);
    localparam logic [DATA_W-1:0] MaxCount = DATA_W'(MAX_NBR);

    typedef enum logic [2:0] {
        StIdle,
        StHdrRd,
        StHdrWait,
        StDatRd,
        StDatWait,
        StSend
    } state_e;

    state_e             state_q, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [REM_W-1:0]   remaining_q, remaining_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               last_q, last_d;
    logic               empty_q, empty_d;
    logic               err_collision_q, err_collision_d;
    logic               err_overflow_q, err_overflow_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= StIdle;
            tag_q           <= '0;
            ptr_q           <= '0;
            remaining_q     <= '0;
            data_q          <= '0;
            last_q          <= 1'b0;
            empty_q         <= 1'b0;
            err_collision_q <= 1'b0;
            err_overflow_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            tag_q           <= tag_d;
            ptr_q           <= ptr_d;
            remaining_q     <= remaining_d;
            data_q          <= data_d;
            last_q          <= last_d;
            empty_q         <= empty_d;
            err_collision_q <= err_collision_d;
            err_overflow_q  <= err_overflow_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        tag_d           = tag_q;
        ptr_d           = ptr_q;
        remaining_d     = remaining_q;
        data_d          = data_q;
        last_d          = last_q;
        empty_d         = empty_q;
        err_overflow_d  = err_overflow_q;
        // Requests that arrive while the bank is occupied are dropped but remembered.
        err_collision_d = err_collision_q | (req_valid && (state_q != StIdle));

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    tag_d   = req_PE_tag;
                    ptr_d   = req_bank_addr;
                    state_d = StHdrRd;
                end
            end
            StHdrRd: begin
                state_d = StHdrWait;
            end
            StHdrWait: begin
                empty_d = 1'b0;
                if (sram_rdata > MaxCount) begin
                    err_overflow_d = 1'b1;
                    remaining_d    = REM_W'(MAX_NBR);
                    state_d        = StDatRd;
                end else if (sram_rdata == '0) begin
                    data_d  = '0;
                    empty_d = 1'b1;
                    last_d  = 1'b1;
                    state_d = StSend;
                end else begin
                    remaining_d = REM_W'(sram_rdata);
                    state_d     = StDatRd;
                end
            end
            StDatRd: begin
                ptr_d   = ptr_q + ADDR_W'(1);
                state_d = StDatWait;
            end
            StDatWait: begin
                data_d      = sram_rdata;
                remaining_d = remaining_q - REM_W'(1);
                last_d      = (remaining_q == REM_W'(1));
                state_d     = StSend;
            end
            StSend: begin
                if (out_ready) begin
                    state_d = last_q ? StIdle : StDatRd;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sram_re   = 1'b0;
        sram_addr = '0;
        if (state_q == StHdrRd) begin
            sram_re   = 1'b1;
            sram_addr = ptr_q;
        end else if (state_q == StDatRd) begin
            sram_re   = 1'b1;
            sram_addr = ptr_q + ADDR_W'(1);
        end
    end

    assign busy          = (state_q != StIdle);
    assign out_valid     = (state_q == StSend);
    assign out_PE_tag    = tag_q;
    assign out_data      = data_q;
    assign out_last      = last_q;
    assign out_empty     = empty_q;
    assign err_collision = err_collision_q;
    assign err_overflow  = err_overflow_q;

endmodule

// File: tb/tb_neighbor_bank_reader.sv
// Directed bench for neighbor_bank_reader with a one-cycle-latency SRAM model.
module tb_neighbor_bank_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_PE_tag;
    logic [7:0]  req_bank_addr;
    logic        busy;
    logic        sram_re;
    logic [7:0]  sram_addr;
    logic [15:0] sram_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_PE_tag;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_empty;
    logic        err_collision;
    logic        err_overflow;

    logic [15:0] mem [256];

    int checks   = 0;
    int failures = 0;

    logic [15:0] beats [$];
    logic        lasts [$];
    logic        empties [$];
    logic [3:0]  tags [$];
    int          busy_cycles;
    int          first_valid;
    logic        timed_out;
    logic        stable_ok;

    neighbor_bank_reader dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_PE_tag    (req_PE_tag),
        .req_bank_addr (req_bank_addr),
        .busy          (busy),
        .sram_re       (sram_re),
        .sram_addr     (sram_addr),
        .sram_rdata    (sram_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_PE_tag    (out_PE_tag),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_empty     (out_empty),
        .err_collision (err_collision),
        .err_overflow  (err_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_re) sram_rdata <= mem[sram_addr];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic request(input logic [3:0] tag, input logic [7:0] addr);
        @(negedge clk);
        req_valid     = 1'b1;
        req_PE_tag    = tag;
        req_bank_addr = addr;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the request edge; stops on the first idle cycle after busy.
    task automatic collect(input int budget, input int stall_beat, input int stall_len,
                           input int inject_cyc);
        int          cyc;
        int          stalled;
        logic        seen_busy;
        logic [15:0] hold;
        beats.delete(); lasts.delete(); empties.delete(); tags.delete();
        busy_cycles = 0;
        first_valid = -1;
        timed_out   = 1'b1;
        stable_ok   = 1'b1;
        cyc         = 0;
        stalled     = 0;
        seen_busy   = 1'b0;
        hold        = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cyc++;
            if (busy) begin
                busy_cycles++;
                seen_busy = 1'b1;
            end else if (seen_busy) begin
                timed_out = 1'b0;
                break;
            end
            if (cyc == inject_cyc) begin
                req_valid     = 1'b1;
                req_PE_tag    = 4'd5;
                req_bank_addr = 8'h20;
            end else begin
                req_valid = 1'b0;
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && beats.size() == stall_beat && stalled < stall_len) begin
                if (stalled > 0 && out_data !== hold) stable_ok = 1'b0;
                hold      = out_data;
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                beats.push_back(out_data);
                lasts.push_back(out_last);
                empties.push_back(out_empty);
                tags.push_back(out_PE_tag);
            end
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        check("collect_timeout", {31'd0, timed_out}, 32'd0);
    endtask

    task automatic check_list(input string name, input logic [3:0] tag, input int n,
                              input logic [15:0] exp [$]);
        check({name, "_count"}, beats.size(), n);
        for (int i = 0; i < n && i < beats.size(); i++) begin
            check($sformatf("%s_data%0d", name, i), beats[i], exp[i]);
            check($sformatf("%s_last%0d", name, i), {31'd0, lasts[i]}, {31'd0, i == n - 1});
            check($sformatf("%s_empty%0d", name, i), {31'd0, empties[i]}, 32'd0);
            check($sformatf("%s_tag%0d", name, i), {28'd0, tags[i]}, {28'd0, tag});
        end
    endtask

    initial begin
        logic [15:0] exp [$];
        for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
        mem[8'h10] = 16'd3;
        mem[8'h11] = 16'h000A;
        mem[8'h12] = 16'h000B;
        mem[8'h13] = 16'h000C;
        mem[8'h20] = 16'd0;
        mem[8'hFE] = 16'd2;
        mem[8'hFF] = 16'd7;
        mem[8'h00] = 16'd9;
        mem[8'h40] = 16'd40;
        for (int i = 1; i <= 40; i++) mem[8'h40 + i] = 16'h0100 + 16'(i);

        reset         = 1'b0;
        req_valid     = 1'b0;
        req_PE_tag    = '0;
        req_bank_addr = '0;
        out_ready     = 1'b1;
        sram_rdata    = '0;
        #12;
        check("rst_outputs", {22'd0, busy, sram_re, sram_addr, out_valid, out_PE_tag, out_data,
                              out_last, out_empty, err_collision, err_overflow} & 32'hFFFF_FFFF,
              32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Three-entry list with ready held high.
        request(4'd2, 8'h10);
        collect(100, -1, 0, 0);
        exp = '{16'h000A, 16'h000B, 16'h000C};
        check_list("basic", 4'd2, 3, exp);
        check("basic_first_valid", first_valid, 5);
        check("basic_busy_cycles", busy_cycles, 11);

        // Empty list yields one marker beat.
        request(4'd3, 8'h20);
        collect(100, -1, 0, 0);
        check("empty_count", beats.size(), 1);
        if (beats.size() == 1) begin
            check("empty_data", beats[0], 32'd0);
            check("empty_last", {31'd0, lasts[0]}, 32'd1);
            check("empty_flag", {31'd0, empties[0]}, 32'd1);
        end
        check("empty_busy_cycles", busy_cycles, 3);

        // List wrapping past the top of the bank.
        request(4'd7, 8'hFE);
        collect(100, -1, 0, 0);
        exp = '{16'h0007, 16'h0009};
        check_list("wrap", 4'd7, 2, exp);
        check("wrap_busy_cycles", busy_cycles, 8);

        // Backpressure on the second beat for four cycles.
        request(4'd2, 8'h10);
        collect(100, 1, 4, 0);
        exp = '{16'h000A, 16'h000B, 16'h000C};
        check_list("stall", 4'd2, 3, exp);
        check("stall_stable", {31'd0, stable_ok}, 32'd1);
        check("stall_busy_cycles", busy_cycles, 15);
        check("pre_collision_flag", {31'd0, err_collision}, 32'd0);

        // Second request while busy is dropped and flagged.
        request(4'd2, 8'h10);
        collect(100, -1, 0, 3);
        exp = '{16'h000A, 16'h000B, 16'h000C};
        check_list("collide", 4'd2, 3, exp);
        check("collide_busy_cycles", busy_cycles, 11);
        check("collide_flag", {31'd0, err_collision}, 32'd1);
        check("pre_overflow_flag", {31'd0, err_overflow}, 32'd0);

        // Header count above the limit saturates.
        request(4'd1, 8'h40);
        collect(300, -1, 0, 0);
        exp.delete();
        for (int i = 1; i <= 32; i++) exp.push_back(16'h0100 + 16'(i));
        check_list("ovf", 4'd1, 32, exp);
        check("ovf_flag", {31'd0, err_overflow}, 32'd1);
        check("ovf_busy_cycles", busy_cycles, 98);

        // Reset in the middle of a list aborts it.
        request(4'd2, 8'h10);
        repeat (5) @(negedge clk);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_outputs", {22'd0, busy, sram_re, sram_addr, out_valid, out_PE_tag,
                                 out_data, out_last, out_empty, err_collision, err_overflow},
              32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_idle%0d", i), {30'd0, busy, out_valid}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
